// File: rtl/sram_bus_pkg.sv
// Shared types and widths for the 68k SRAM bus responder.
// Holds the FSM state enum, block index type and counter widths.
package sram_bus_pkg;

  localparam int WAIT_W     = 4;
  localparam int REC_W      = 3;
  localparam int NUM_BLOCKS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2,
    ACK     = 2'd3
  } state_t;

  typedef logic [1:0] block_idx_t;

  function automatic logic [NUM_BLOCKS-1:0] block_onehot(
    input block_idx_t idx
  );
    return NUM_BLOCKS'(1) << idx;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag.
// Shared by the ACCESS and RECOVER phases of the SRAM responder.
module sram_wait_counter
  import sram_bus_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_bus_responder.sv
// 68k bus responder for the 256 KB SRAM region with wait states.
// Optional block-0 write protect with BERR: SRAM_WRITE_PROTECT_EN.
module sram_bus_responder
  import sram_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int WR_RECOVERY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic [16:0]           Address,
  input  logic                  SRamSelect_H,
  input  logic                  AS_L,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  input  logic                  RW,
  output logic [NUM_BLOCKS-1:0] Block_H,
  output logic                  SramOE_L,
  output logic                  SramWEU_L,
  output logic                  SramWEL_L,
  output logic                  DtackOut_L
`ifdef SRAM_WRITE_PROTECT_EN
  ,
  output logic                  BERR_L,
  input  logic                  WriteProt_H
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    WAIT_W'(WAIT_STATES);
  localparam logic [WAIT_W-1:0] REC_LOAD =
    (WR_RECOVERY > 0) ? WAIT_W'(WR_RECOVERY - 1) : '0;
  localparam bit NO_REC = (WR_RECOVERY == 0);

  state_t     state;
  block_idx_t blk_q;
  logic       rd_q;
  logic       u_q;
  logic       l_q;
  logic       prot_q;

  logic              start;
  logic              prot_start;
  logic              cnt_load;
  logic [WAIT_W-1:0] cnt_val;
  logic              cnt_zero;
  logic              unused_addr;

  assign unused_addr = ^Address[14:0];

  assign start = SRamSelect_H & ~AS_L
               & (~UDS_L | ~LDS_L);

`ifdef SRAM_WRITE_PROTECT_EN
  assign prot_start = ~RW & WriteProt_H
                    & (Address[16:15] == 2'd0);
`else
  assign prot_start = 1'b0;
`endif

  // Idle keeps the access count preloaded; the ACCESS
  // exit reloads it for the recovery phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = WAIT_LOAD;
    if (state == IDLE) begin
      cnt_load = 1'b1;
    end else if (state == ACCESS && cnt_zero) begin
      cnt_load = 1'b1;
      cnt_val  = REC_LOAD;
    end
  end

  sram_wait_counter #(
    .W(WAIT_W)
  ) u_cnt (
    .clk     (Clock),
    .rst_n   (Reset_L),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state  <= IDLE;
      blk_q  <= '0;
      rd_q   <= 1'b1;
      u_q    <= 1'b0;
      l_q    <= 1'b0;
      prot_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= ACCESS;
            blk_q  <= Address[16:15];
            rd_q   <= RW;
            u_q    <= ~UDS_L;
            l_q    <= ~LDS_L;
            prot_q <= prot_start;
          end
        end
        ACCESS: begin
          if (AS_L) begin
            state <= IDLE;
          end else if (cnt_zero) begin
            if (rd_q || prot_q || NO_REC) begin
              state <= ACK;
            end else begin
              state <= RECOVER;
            end
          end
        end
        RECOVER: begin
          if (AS_L) begin
            state <= IDLE;
          end else if (cnt_zero) begin
            state <= ACK;
          end
        end
        ACK: begin
          if (AS_L) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are registered from the state held in the
  // preceding cycle, so each phase shows one edge later.
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      Block_H    <= '0;
      SramOE_L   <= 1'b1;
      SramWEU_L  <= 1'b1;
      SramWEL_L  <= 1'b1;
      DtackOut_L <= 1'b1;
`ifdef SRAM_WRITE_PROTECT_EN
      BERR_L     <= 1'b1;
`endif
    end else begin
      Block_H    <= '0;
      SramOE_L   <= 1'b1;
      SramWEU_L  <= 1'b1;
      SramWEL_L  <= 1'b1;
      DtackOut_L <= 1'b1;
`ifdef SRAM_WRITE_PROTECT_EN
      BERR_L     <= 1'b1;
`endif
      unique case (1'b1)
        (state == ACCESS): begin
          Block_H   <= block_onehot(blk_q);
          SramOE_L  <= ~rd_q;
          SramWEU_L <= rd_q | prot_q | ~u_q;
          SramWEL_L <= rd_q | prot_q | ~l_q;
        end
        (state == RECOVER): begin
          Block_H <= block_onehot(blk_q);
        end
        (state == ACK): begin
          if (rd_q) begin
            Block_H  <= block_onehot(blk_q);
            SramOE_L <= 1'b0;
          end
`ifdef SRAM_WRITE_PROTECT_EN
          if (prot_q) BERR_L <= 1'b0;
          else
`endif
          DtackOut_L <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
